// File: rtl/sword_attack_ctrl.sv
// Player sword attack controller: WINDUP/ACTIVE/RECOVER swing timed in game ticks,
// a zero-latency raster hitbox, and a one-hit-per-swing overlap detector.
module sword_attack_ctrl #(
    parameter int unsigned WINDUP_TICKS  = 4,
    parameter int unsigned ACTIVE_TICKS  = 12,
    parameter int unsigned RECOVER_TICKS = 8,
    parameter int unsigned SWORD_LEN     = 24,
    parameter int unsigned SWORD_H       = 8,
    parameter int unsigned SWORD_YOFS    = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        attack_btn,
    input  logic [31:0] player_realposX,
    input  logic [31:0] player_realposY,
    input  logic        facing_left,
    input  logic [31:0] CounterX,
    input  logic [31:0] CounterY,
    input  logic        mob_pixel,
    output logic        SwordBox,
    output logic        attack_active,
    output logic [1:0]  attack_state,
    output logic        hit_pulse,
    output logic [7:0]  hit_count
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WINDUP  = 2'd1;
    localparam logic [1:0] ST_ACTIVE  = 2'd2;
    localparam logic [1:0] ST_RECOVER = 2'd3;

    localparam int unsigned MAX_WA = (WINDUP_TICKS > ACTIVE_TICKS) ? WINDUP_TICKS : ACTIVE_TICKS;
    localparam int unsigned MAX_T  = (MAX_WA > RECOVER_TICKS) ? MAX_WA : RECOVER_TICKS;
    localparam int unsigned CNT_W  = (MAX_T > 1) ? $clog2(MAX_T) : 1;

    localparam logic [CNT_W-1:0] WINDUP_LAST  = CNT_W'(WINDUP_TICKS - 1);
    localparam logic [CNT_W-1:0] ACTIVE_LAST  = CNT_W'(ACTIVE_TICKS - 1);
    localparam logic [CNT_W-1:0] RECOVER_LAST = CNT_W'(RECOVER_TICKS - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             btn_q;
    logic             hit_done_q, hit_done_d;
    logic             hit_pulse_q, hit_pulse_d;
    logic [7:0]       hit_count_q, hit_count_d;
    logic             active_q, active_d;

    logic        press;
    logic [31:0] xlo, xhi, ylo, yhi;
    logic        overlap;

    assign press = attack_btn & ~btn_q;

    // Sword rectangle from live player position; underflowing edges clamp to 0.
    always_comb begin
        yhi = player_realposY - 32'(SWORD_YOFS);
        if (player_realposY < 32'(SWORD_YOFS + SWORD_H)) begin
            ylo = 32'd0;
        end else begin
            ylo = player_realposY - 32'(SWORD_YOFS + SWORD_H);
        end
        if (facing_left) begin
            xhi = player_realposX;
            xlo = (player_realposX < 32'(SWORD_LEN)) ? 32'd0 : player_realposX - 32'(SWORD_LEN);
        end else begin
            xlo = player_realposX + 32'd32;
            xhi = player_realposX + 32'd32 + 32'(SWORD_LEN);
        end
    end

    assign SwordBox = (state_q == ST_ACTIVE) &&
                      (CounterX >= xlo) && (CounterX < xhi) &&
                      (CounterY >= ylo) && (CounterY < yhi);
    assign overlap  = SwordBox & mob_pixel;

    // Next-state, tick counting and hit bookkeeping.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hit_done_d  = hit_done_q;
        hit_pulse_d = 1'b0;
        hit_count_d = hit_count_q;

        case (state_q)
            ST_IDLE: begin
                if (press) begin
                    state_d    = ST_WINDUP;
                    cnt_d      = '0;
                    hit_done_d = 1'b0;
                end
            end
            ST_WINDUP: begin
                if (tick) begin
                    if (cnt_q == WINDUP_LAST) begin
                        state_d = ST_ACTIVE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_ACTIVE: begin
                if (tick) begin
                    if (cnt_q == ACTIVE_LAST) begin
                        state_d = ST_RECOVER;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                if (tick) begin
                    if (cnt_q == RECOVER_LAST) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
        endcase

        if (overlap && !hit_done_q) begin
            hit_pulse_d = 1'b1;
            hit_done_d  = 1'b1;
            if (hit_count_q != 8'hFF) begin
                hit_count_d = hit_count_q + 8'd1;
            end
        end

        active_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            btn_q       <= 1'b0;
            hit_done_q  <= 1'b0;
            hit_pulse_q <= 1'b0;
            hit_count_q <= 8'd0;
            active_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            btn_q       <= attack_btn;
            hit_done_q  <= hit_done_d;
            hit_pulse_q <= hit_pulse_d;
            hit_count_q <= hit_count_d;
            active_q    <= active_d;
        end
    end

    assign attack_state  = state_q;
    assign attack_active = active_q;
    assign hit_pulse     = hit_pulse_q;
    assign hit_count     = hit_count_q;

endmodule

// File: tb/tb_sword_attack_ctrl.sv
// Directed self-checking bench for sword_attack_ctrl: swing timing, hitbox edges,
// hit detection, dropped presses, reset abort and hit counter saturation.
module tb_sword_attack_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick;
    logic        attack_btn;
    logic [31:0] player_realposX;
    logic [31:0] player_realposY;
    logic        facing_left;
    logic [31:0] CounterX;
    logic [31:0] CounterY;
    logic        mob_pixel;
    logic        SwordBox;
    logic        attack_active;
    logic [1:0]  attack_state;
    logic        hit_pulse;
    logic [7:0]  hit_count;

    int checks = 0;
    int passed = 0;
    int fails  = 0;
    int ones;
    int pulses;

    always #5 clk = ~clk;

    sword_attack_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .tick            (tick),
        .attack_btn      (attack_btn),
        .player_realposX (player_realposX),
        .player_realposY (player_realposY),
        .facing_left     (facing_left),
        .CounterX        (CounterX),
        .CounterY        (CounterY),
        .mob_pixel       (mob_pixel),
        .SwordBox        (SwordBox),
        .attack_active   (attack_active),
        .attack_state    (attack_state),
        .hit_pulse       (hit_pulse),
        .hit_count       (hit_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Each tick is a one-cycle strobe followed by one quiet cycle.
    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            cyc();
            tick = 1'b0;
            cyc();
        end
    endtask

    task automatic press();
        attack_btn = 1'b1;
        cyc();
        attack_btn = 1'b0;
        cyc();
    endtask

    task automatic raster(input logic [31:0] x, input logic [31:0] y);
        CounterX = x;
        CounterY = y;
        #1;
    endtask

    // One full swing with a single-pixel overlap during ACTIVE.
    task automatic swing_hit(output int got_pulse);
        got_pulse = 0;
        press();
        tick_n(4);
        raster(32'd140, 32'd284);
        mob_pixel = 1'b1;
        cyc();
        mob_pixel = 1'b0;
        raster(32'd0, 32'd0);
        if (hit_pulse === 1'b1) got_pulse = 1;
        tick_n(12);
        tick_n(8);
    endtask

    initial begin
        int gp;
        rst = 1'b1; tick = 1'b0; attack_btn = 1'b0;
        player_realposX = 32'd100; player_realposY = 32'd300; facing_left = 1'b0;
        CounterX = 32'd0; CounterY = 32'd0; mob_pixel = 1'b0;
        repeat (3) cyc();
        rst = 1'b0;
        cyc();
        chk("rst_state", 32'(attack_state), 32'd0);
        chk("rst_active", 32'(attack_active), 32'd0);
        chk("rst_count", 32'(hit_count), 32'd0);
        chk("rst_pulse", 32'(hit_pulse), 32'd0);
        chk("rst_box", 32'(SwordBox), 32'd0);

        // Swing timing
        press();
        chk("t1_windup", 32'(attack_state), 32'd1);
        chk("t1_active_flag", 32'(attack_active), 32'd1);
        tick_n(3);
        chk("t1_windup_3", 32'(attack_state), 32'd1);
        tick_n(1);
        chk("t1_active", 32'(attack_state), 32'd2);
        tick_n(11);
        chk("t1_active_11", 32'(attack_state), 32'd2);
        tick_n(1);
        chk("t1_recover", 32'(attack_state), 32'd3);
        tick_n(7);
        chk("t1_recover_7", 32'(attack_state), 32'd3);
        tick_n(1);
        chk("t1_idle", 32'(attack_state), 32'd0);
        chk("t1_idle_flag", 32'(attack_active), 32'd0);

        // Facing right hitbox: X 132..155, Y 280..287
        press();
        tick_n(4);
        chk("t2_in_active", 32'(attack_state), 32'd2);
        ones = 0;
        for (int y = 280; y < 288; y++)
            for (int x = 132; x < 156; x++) begin
                raster(32'(x), 32'(y));
                if (SwordBox === 1'b1) ones++;
            end
        chk("t2_box_count", 32'(ones), 32'd192);
        raster(32'd156, 32'd280); chk("t2_x_hi", 32'(SwordBox), 32'd0);
        raster(32'd131, 32'd280); chk("t2_x_lo", 32'(SwordBox), 32'd0);
        raster(32'd140, 32'd288); chk("t2_y_hi", 32'(SwordBox), 32'd0);
        raster(32'd140, 32'd279); chk("t2_y_lo", 32'(SwordBox), 32'd0);

        // Facing left near screen edge: X 0..9, no wrap
        player_realposX = 32'd10;
        facing_left = 1'b1;
        ones = 0;
        for (int y = 280; y < 288; y++)
            for (int x = 0; x < 10; x++) begin
                raster(32'(x), 32'(y));
                if (SwordBox === 1'b1) ones++;
            end
        chk("t3_box_count", 32'(ones), 32'd80);
        raster(32'd10, 32'd280); chk("t3_x_hi", 32'(SwordBox), 32'd0);
        raster(32'd4294967290, 32'd280); chk("t3_no_wrap", 32'(SwordBox), 32'd0);
        facing_left = 1'b0;
        raster(32'd42, 32'd280); chk("t3_turn_new", 32'(SwordBox), 32'd1);
        raster(32'd5, 32'd280); chk("t3_turn_old", 32'(SwordBox), 32'd0);
        player_realposX = 32'd100;
        raster(32'd0, 32'd0);
        tick_n(12);
        tick_n(8);
        chk("t3_idle", 32'(attack_state), 32'd0);
        chk("t3_no_hit", 32'(hit_count), 32'd0);

        // 50 overlapping pixels in one swing -> one hit
        press();
        tick_n(4);
        mob_pixel = 1'b1;
        pulses = 0;
        for (int i = 0; i < 50; i++) begin
            raster(32'(132 + (i % 24)), 32'(280 + (i / 24)));
            cyc();
            if (hit_pulse === 1'b1) pulses++;
        end
        mob_pixel = 1'b0;
        raster(32'd0, 32'd0);
        cyc();
        if (hit_pulse === 1'b1) pulses++;
        chk("t4_one_pulse", 32'(pulses), 32'd1);
        chk("t4_count1", 32'(hit_count), 32'd1);
        tick_n(12);
        tick_n(8);
        press();
        tick_n(4);
        mob_pixel = 1'b1;
        tick_n(12);
        mob_pixel = 1'b0;
        tick_n(8);
        chk("t4_count_stays", 32'(hit_count), 32'd1);

        // Presses outside IDLE are dropped
        press();
        press();
        tick_n(4);
        chk("t5_active", 32'(attack_state), 32'd2);
        press();
        tick_n(12);
        chk("t5_recover", 32'(attack_state), 32'd3);
        press();
        tick_n(8);
        chk("t5_idle_no_queue", 32'(attack_state), 32'd0);
        cyc();
        chk("t5_still_idle", 32'(attack_state), 32'd0);
        attack_btn = 1'b1;
        tick = 1'b1;
        cyc();
        attack_btn = 1'b0;
        tick = 1'b0;
        cyc();
        chk("t5_press_tick", 32'(attack_state), 32'd1);
        tick_n(3);
        chk("t5_tick_not_counted", 32'(attack_state), 32'd1);
        tick_n(1);
        chk("t5_to_active", 32'(attack_state), 32'd2);

        // Reset mid-ACTIVE with an overlap on the reset edge
        raster(32'd140, 32'd284);
        chk("t6_box_live", 32'(SwordBox), 32'd1);
        mob_pixel = 1'b1;
        rst = 1'b1;
        cyc();
        chk("t6_box_off", 32'(SwordBox), 32'd0);
        chk("t6_state", 32'(attack_state), 32'd0);
        chk("t6_count", 32'(hit_count), 32'd0);
        chk("t6_pulse", 32'(hit_pulse), 32'd0);
        rst = 1'b0;
        mob_pixel = 1'b0;
        raster(32'd0, 32'd0);
        cyc();

        // Saturation at 255
        for (int s = 0; s < 255; s++) swing_hit(gp);
        chk("t6_count255", 32'(hit_count), 32'd255);
        swing_hit(gp);
        chk("t6_sat_pulse", 32'(gp), 32'd1);
        chk("t6_sat_hold", 32'(hit_count), 32'd255);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
